// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for the RISC-V datapath: instruction/data memory
// handshakes with a bus-error timeout, trap entry with EPC/cause capture.
module mc_sequencer #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] TRAP_VEC    = 'hFE,
    parameter int unsigned     CAUSE_W     = 2,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    pc,
    input  logic               alu_zero,
    input  logic               alu_lt,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic               ir_load,
    output logic               ab_load,
    output logic               aluout_load,
    output logic               mdr_load,
    output logic               rf_we,
    output logic               pc_load,
    output logic [1:0]         pc_sel,
    output logic [XLEN-1:0]    epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               trap,
    output logic [2:0]         state_out
);

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL   = CAUSE_W'(2);

    localparam int unsigned       CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MEM_TIMEOUT);

    logic [2:0]         state, state_nx;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
    logic [CAUSE_W-1:0] trap_code, trap_code_nx;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               br_taken, br_valid;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign state_out = state;

    always_comb begin
        br_valid = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            default: br_valid = 1'b0;
        endcase
    end

    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_load      = 1'b0;
        ab_load      = 1'b0;
        aluout_load  = 1'b0;
        mdr_load     = 1'b0;
        rf_we        = 1'b0;
        pc_load      = 1'b0;
        pc_sel       = 2'd0;
        trap         = 1'b0;
        state_nx     = state;
        wait_cnt_nx  = '0;
        trap_code_nx = trap_code;
        case (state)
            S_RST: state_nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load  = 1'b1;
                    pc_load  = 1'b1;
                    state_nx = S_DECODE;
                end else if (wait_cnt == CNT_MAX) begin
                    state_nx     = S_TRAP;
                    trap_code_nx = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                ab_load     = 1'b1;
                aluout_load = 1'b1;
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_JAL, OP_BRANCH:
                        state_nx = S_EXEC;
                    OP_SYSTEM: begin
                        if (instr == 32'h0000_0073) begin
                            state_nx     = S_TRAP;
                            trap_code_nx = CAUSE_ECALL;
                        end else if (instr == 32'h0010_0073) begin
                            state_nx = S_HALT;
                        end else begin
                            state_nx     = S_TRAP;
                            trap_code_nx = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_nx     = S_TRAP;
                        trap_code_nx = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    if (!br_valid) begin
                        state_nx     = S_TRAP;
                        trap_code_nx = CAUSE_ILLEGAL;
                    end else begin
                        pc_load  = br_taken;
                        pc_sel   = br_taken ? 2'd1 : 2'd0;
                        state_nx = S_FETCH;
                    end
                end else begin
                    aluout_load = 1'b1;
                    if (opcode == OP_JAL) begin
                        pc_load = 1'b1;
                        pc_sel  = 2'd1;
                    end
                    state_nx = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ready) begin
                    mdr_load = (opcode != OP_STORE);
                    state_nx = (opcode == OP_STORE) ? S_FETCH : S_WB;
                end else if (wait_cnt == CNT_MAX) begin
                    state_nx     = S_TRAP;
                    trap_code_nx = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_load  = 1'b1;
                pc_sel   = 2'd2;
                state_nx = S_FETCH;
            end
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_RST;
        endcase
    end

    // TRAP_VEC itself feeds the datapath PC mux; only its alignment is checked here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RST;
            wait_cnt  <= '0;
            trap_code <= '0;
            epc       <= '0;
            cause     <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            trap_code <= trap_code_nx;
            if (state == S_TRAP) begin
                assert (TRAP_VEC[0] == 1'b0);
                epc   <= pc;
                cause <= trap_code;
            end
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-instruction cycle scripts built from the latency and
// handshake rules, replayed against the DUT and compared every cycle.
module tb_mc_sequencer;

    localparam int unsigned TMO = 15;

    localparam logic [2:0] S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6, S_HALT = 3'd7;

    localparam logic [11:0] IREQ = 12'h800, DREQ = 12'h400, DWE  = 12'h200, IRL  = 12'h100;
    localparam logic [11:0] ABL  = 12'h080, AOL  = 12'h040, MDRL = 12'h020, RFWE = 12'h010;
    localparam logic [11:0] PCL  = 12'h008, SEL1 = 12'h002, SEL2 = 12'h004, TRP  = 12'h001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        alu_zero, alu_lt, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_load, ab_load, aluout_load, mdr_load;
    logic        rf_we, pc_load, trap;
    logic [1:0]  pc_sel;
    logic [63:0] epc;
    logic [1:0]  cause;
    logic [2:0]  state_out;

    always #5 clk = ~clk;

    mc_sequencer #(.XLEN(64), .TRAP_VEC(64'hFE), .CAUSE_W(2), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .ir_load(ir_load), .ab_load(ab_load), .aluout_load(aluout_load),
        .mdr_load(mdr_load), .rf_we(rf_we), .pc_load(pc_load), .pc_sel(pc_sel), .epc(epc),
        .cause(cause), .trap(trap), .state_out(state_out)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        imr, dmr, az, alt;
        logic [2:0]  st;
        logic [11:0] o;
        logic        upd;
        logic [63:0] n_epc;
        logic [1:0]  n_cause;
    } cyc_t;

    cyc_t        script[$];
    cyc_t        cur;
    logic        cur_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        m_rst = 1'b1, m_tie = 1'b0, m_upd = 1'b0, m_az = 1'b0, m_alt = 1'b0;
    logic [31:0] m_instr = '0;
    logic [63:0] m_pc = '0, m_nepc = '0, m_epc = '0;
    logic [1:0]  m_ncause = '0, m_cause = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input logic [2:0] st, input logic [11:0] o, input logic imr, input logic dmr);
        cyc_t e;
        e.rst_n = m_rst;  e.instr = m_instr;  e.pc = m_pc;
        e.imr = m_tie ? 1'b1 : imr;
        e.dmr = m_tie ? 1'b1 : dmr;
        e.az = m_az;  e.alt = m_alt;  e.st = st;  e.o = o;
        e.upd = m_upd;  e.n_epc = m_nepc;  e.n_cause = m_ncause;
        script.push_back(e);
    endfunction

    function automatic void push_trap(input logic [1:0] code);
        m_upd = 1'b1;  m_nepc = m_pc;  m_ncause = code;
        push(S_TRAP, PCL | SEL2 | TRP, 1'b0, 1'b0);
        m_upd = 1'b0;
    endfunction

    // Wait cycles of a request; returns 0 when the access times out into a trap.
    function automatic bit mem_wait(input logic [2:0] st, input logic [11:0] o, input int unsigned w);
        int unsigned n = (w > TMO) ? TMO + 1 : w;
        for (int unsigned i = 0; i < n; i++) push(st, o, 1'b0, 1'b0);
        if (w > TMO) begin
            push_trap(2'd1);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void add_instr(input logic [31:0] ins, input logic [63:0] p,
                                      input int unsigned iw, input int unsigned dw,
                                      input logic az, input logic alt);
        logic taken;
        m_instr = ins;  m_pc = p;  m_az = az;  m_alt = alt;
        if (!mem_wait(S_FETCH, IREQ, iw)) return;
        push(S_FETCH, IREQ | IRL | PCL, 1'b1, 1'b0);
        push(S_DECODE, ABL | AOL, 1'b0, 1'b0);
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0110111: begin
                push(S_EXEC, AOL, 1'b0, 1'b0);
                push(S_WB, RFWE, 1'b0, 1'b0);
            end
            7'b1101111: begin
                push(S_EXEC, AOL | PCL | SEL1, 1'b0, 1'b0);
                push(S_WB, RFWE, 1'b0, 1'b0);
            end
            7'b0000011: begin
                push(S_EXEC, AOL, 1'b0, 1'b0);
                if (!mem_wait(S_MEM, DREQ, dw)) return;
                push(S_MEM, DREQ | MDRL, 1'b0, 1'b1);
                push(S_WB, RFWE, 1'b0, 1'b0);
            end
            7'b0100011: begin
                push(S_EXEC, AOL, 1'b0, 1'b0);
                if (!mem_wait(S_MEM, DREQ | DWE, dw)) return;
                push(S_MEM, DREQ | DWE, 1'b0, 1'b1);
            end
            7'b1100011: begin
                case (ins[14:12])
                    3'b000: taken = az;
                    3'b001: taken = !az;
                    3'b100: taken = alt;
                    3'b101: taken = !alt;
                    default: begin
                        push(S_EXEC, 12'h000, 1'b0, 1'b0);
                        push_trap(2'd0);
                        return;
                    end
                endcase
                push(S_EXEC, taken ? (PCL | SEL1) : 12'h000, 1'b0, 1'b0);
            end
            7'b1110011: begin
                if (ins == 32'h0000_0073) push_trap(2'd2);
                else if (ins == 32'h0010_0073)
                    for (int unsigned i = 0; i < 3; i++) push(S_HALT, 12'h000, 1'b0, 1'b0);
                else push_trap(2'd0);
            end
            default: push_trap(2'd0);
        endcase
    endfunction

    // Reset asserted during a cycle of state st; the following cycle is RST.
    function automatic void reset_at(input logic [2:0] st, input logic [11:0] o);
        m_rst = 1'b0;  m_upd = 1'b1;  m_nepc = '0;  m_ncause = '0;
        push(st, o, 1'b0, 1'b0);
        m_rst = 1'b1;  m_upd = 1'b0;
        push(S_RST, 12'h000, 1'b0, 1'b0);
    endfunction

    task automatic run();
        cyc_t e;
        while (script.size() > 0) begin
            e = script.pop_front();
            @(posedge clk);
            #1;
            reset = e.rst_n;  instr = e.instr;  pc = e.pc;
            imem_ready = e.imr;  dmem_ready = e.dmr;  alu_zero = e.az;  alu_lt = e.alt;
            cur = e;
            cur_valid = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("state", {61'd0, state_out}, {61'd0, cur.st});
            chk("strobes", {52'd0, imem_req, dmem_req, dmem_we, ir_load, ab_load, aluout_load,
                            mdr_load, rf_we, pc_load, pc_sel, trap}, {52'd0, cur.o});
            chk("epc", epc, m_epc);
            chk("cause", {62'd0, cause}, {62'd0, m_cause});
            if (cur.upd) begin
                m_epc   = cur.n_epc;
                m_cause = cur.n_cause;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0;  instr = '0;  pc = '0;  alu_zero = 1'b0;  alu_lt = 1'b0;
        imem_ready = 1'b0;  dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        push(S_RST, 12'h000, 1'b0, 1'b0);
        run();

        n = script.size();  m_tie = 1'b1;
        add_instr(32'h002081B3, 64'h1000, 0, 0, 1'b0, 1'b0);
        m_tie = 1'b0;
        chk("len_add", 64'(script.size() - n), 64'd4);
        run();

        n = script.size();
        add_instr(32'h0000B103, 64'h1004, 0, 3, 1'b0, 1'b0);
        chk("len_load_w3", 64'(script.size() - n), 64'd8);
        run();

        n = script.size();
        add_instr(32'h00208463, 64'h1008, 0, 0, 1'b1, 1'b0);
        chk("len_beq", 64'(script.size() - n), 64'd3);
        add_instr(32'h00208463, 64'h100C, 0, 0, 1'b0, 1'b0);
        add_instr(32'h00209463, 64'h1010, 0, 0, 1'b0, 1'b0);
        add_instr(32'h0020C463, 64'h1014, 0, 0, 1'b0, 1'b1);
        add_instr(32'h0020D463, 64'h1018, 0, 0, 1'b1, 1'b1);
        add_instr(32'h00108093, 64'h101C, 0, 0, 1'b0, 1'b0);
        add_instr(32'h000010B7, 64'h1020, 0, 0, 1'b0, 1'b0);
        add_instr(32'h008000EF, 64'h1024, 0, 0, 1'b0, 1'b0);
        m_tie = 1'b1;
        add_instr(32'h0020B023, 64'h1028, 0, 0, 1'b0, 1'b0);
        m_tie = 1'b0;
        add_instr(32'h002081B3, 64'h102C, 2, 0, 1'b0, 1'b0);
        run();

        add_instr(32'hFFFFFFFF, 64'h40, 0, 0, 1'b0, 1'b0);
        add_instr(32'h002081B3, 64'h44, 0, 0, 1'b0, 1'b0);
        run();
        chk("epc_illegal", epc, 64'h40);
        chk("cause_illegal", {62'd0, cause}, 64'd0);

        add_instr(32'h00000073, 64'h200, 0, 0, 1'b0, 1'b0);
        add_instr(32'h002081B3, 64'h204, 0, 0, 1'b0, 1'b0);
        run();
        chk("epc_ecall", epc, 64'h200);
        chk("cause_ecall", {62'd0, cause}, 64'd2);

        add_instr(32'h0020A463, 64'h300, 0, 0, 1'b0, 1'b0);
        run();

        n = script.size();
        add_instr(32'h0020B023, 64'h400, 0, 20, 1'b0, 1'b0);
        chk("len_store_tmo", 64'(script.size() - n), 64'd20);
        add_instr(32'h002081B3, 64'h404, 0, 0, 1'b0, 1'b0);
        run();
        chk("cause_tmo", {62'd0, cause}, 64'd1);
        chk("epc_tmo", epc, 64'h400);

        n = script.size();
        add_instr(32'h0000B103, 64'h500, 0, 15, 1'b0, 1'b0);
        chk("len_load_w15", 64'(script.size() - n), 64'd20);
        run();

        m_instr = 32'h002081B3;  m_pc = 64'h600;
        for (int i = 0; i < 9; i++) push(S_FETCH, IREQ, 1'b0, 1'b0);
        reset_at(S_FETCH, IREQ);
        n = script.size();
        add_instr(32'h002081B3, 64'h600, 20, 0, 1'b0, 1'b0);
        chk("len_fetch_tmo", 64'(script.size() - n), 64'd17);
        run();

        add_instr(32'h00100073, 64'h700, 0, 0, 1'b0, 1'b0);
        reset_at(S_HALT, 12'h000);
        add_instr(32'h002081B3, 64'h800, 0, 0, 1'b0, 1'b0);
        run();
        chk("epc_after_reset", epc, 64'h0);

        @(posedge clk);
        cur_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
